// File: rtl/aux_map_pkg.sv
// Aux display memory layout and writer FSM state encoding shared by the aux memory writer slice.
package aux_map_pkg;

    localparam int AUX_PC         = 0;
    localparam int AUX_INSTR_IN   = 1;
    localparam int AUX_DATA_ADDR  = 2;
    localparam int AUX_DATA_IN    = 3;
    localparam int AUX_IR         = 4;
    localparam int AUX_ACC        = 5;
    localparam int AUX_ALU_A      = 6;
    localparam int AUX_ALU_B      = 7;
    localparam int AUX_CLOCK      = 8;
    localparam int AUX_STATUS     = 9;
    localparam int AUX_INSTR_BASE = 10;
    localparam int AUX_DATA_BASE  = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } writer_state_e;

endpackage

// File: rtl/memory_window_base.sv
// Clamps a CPU address to the first address of a display window that stays inside memory.
module memory_window_base #(
    parameter int VALUE_WIDTH = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int WINDOW      = 10
) (
    input  logic [VALUE_WIDTH-1:0] value_i,
    output logic [ADDR_WIDTH-1:0]  base_o
);
    localparam logic [VALUE_WIDTH-1:0] LAST_V  = VALUE_WIDTH'((1 << ADDR_WIDTH) - 1);
    localparam logic [VALUE_WIDTH-1:0] HALF_V  = VALUE_WIDTH'(WINDOW / 2);
    localparam logic [VALUE_WIDTH-1:0] LEAD_V  = VALUE_WIDTH'(WINDOW / 2 - 1);
    localparam logic [VALUE_WIDTH-1:0] TOP_V   = VALUE_WIDTH'((1 << ADDR_WIDTH) - WINDOW);

    // Full-width compare so out-of-range values still pin to the top window.
    always_comb begin
        base_o = {ADDR_WIDTH{1'b0}};
        if (value_i < HALF_V) begin
            base_o = {ADDR_WIDTH{1'b0}};
        end else if (value_i > (LAST_V - HALF_V)) begin
            base_o = ADDR_WIDTH'(TOP_V);
        end else begin
            base_o = ADDR_WIDTH'(value_i - LEAD_V);
        end
    end

endmodule

// File: rtl/aux_memory_writer.sv
// Snapshots CPU state and memory windows into aux RAM once per refresh request.
// Optional overrun_out port and sticky flag enabled by defining AUX_WRITER_OVERRUN_FLAG_EN.
module aux_memory_writer
    import aux_map_pkg::*;
#(
    parameter int DATA_WIDTH           = 16,
    parameter int MEMORY_ADDRESS_WIDTH = 11,
    parameter int AUX_ADDRESS_WIDTH    = 5,
    parameter int CPU_ELEMENTS         = 10,
    parameter int MEMORY_ELEMENTS      = 10
) (
    input  logic                            clock_in,
    input  logic                            reset_in,
    input  logic                            refresh_in,
    input  logic [DATA_WIDTH-1:0]           pc_in,
    input  logic [DATA_WIDTH-1:0]           instr_in,
    input  logic [DATA_WIDTH-1:0]           data_address_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [DATA_WIDTH-1:0]           ir_in,
    input  logic [DATA_WIDTH-1:0]           acc_in,
    input  logic [DATA_WIDTH-1:0]           alu_a_in,
    input  logic [DATA_WIDTH-1:0]           alu_b_in,
    input  logic                            clock_level_in,
    input  logic                            status_z_in,
    input  logic                            status_n_in,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] instr_raddress_out,
    input  logic [DATA_WIDTH-1:0]           instr_rdata_in,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] data_raddress_out,
    input  logic [DATA_WIDTH-1:0]           data_rdata_in,
    output logic [AUX_ADDRESS_WIDTH-1:0]    aux_waddress_out,
    output logic [DATA_WIDTH-1:0]           aux_wdata_out,
    output logic                            aux_we_out,
    output logic                            busy_out,
    output logic                            done_out
`ifdef AUX_WRITER_OVERRUN_FLAG_EN
    ,
    output logic                            overrun_out
`endif
);
    localparam int CW = 6;
    localparam int SW = $clog2(CPU_ELEMENTS);
    // Read data lands two cycles after its address is issued (RAM latency plus output register).
    localparam logic [CW-1:0] CPU_LAST      = CW'(CPU_ELEMENTS);
    localparam logic [CW-1:0] I_ISSUE_FIRST = CW'(CPU_ELEMENTS + 1);
    localparam logic [CW-1:0] I_ISSUE_LAST  = CW'(CPU_ELEMENTS + MEMORY_ELEMENTS);
    localparam logic [CW-1:0] D_ISSUE_FIRST = CW'(CPU_ELEMENTS + MEMORY_ELEMENTS + 1);
    localparam logic [CW-1:0] D_ISSUE_LAST  = CW'(CPU_ELEMENTS + 2 * MEMORY_ELEMENTS);
    localparam logic [CW-1:0] I_WR_FIRST    = CW'(CPU_ELEMENTS + 3);
    localparam logic [CW-1:0] I_WR_LAST     = CW'(CPU_ELEMENTS + MEMORY_ELEMENTS + 2);
    localparam logic [CW-1:0] D_WR_FIRST    = CW'(CPU_ELEMENTS + MEMORY_ELEMENTS + 3);
    localparam logic [CW-1:0] D_WR_LAST     = CW'(CPU_ELEMENTS + 2 * MEMORY_ELEMENTS + 2);
    localparam logic [CW-1:0] DONE_CYC      = CW'(CPU_ELEMENTS + 2 * MEMORY_ELEMENTS + 3);

    writer_state_e                   state_q;
    logic [CW-1:0]                   cyc_q;
    logic [DATA_WIDTH-1:0]           shadow_q [CPU_ELEMENTS];
    logic [MEMORY_ADDRESS_WIDTH-1:0] ibase_q;
    logic [MEMORY_ADDRESS_WIDTH-1:0] dbase_q;
    logic [MEMORY_ADDRESS_WIDTH-1:0] ibase_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] dbase_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] instr_raddr_q;
    logic [MEMORY_ADDRESS_WIDTH-1:0] data_raddr_q;
    logic [AUX_ADDRESS_WIDTH-1:0]    aux_waddr_q;
    logic [DATA_WIDTH-1:0]           aux_wdata_q;
    logic                            aux_we_q;
    logic                            busy_q;
    logic                            done_q;
    logic [SW-1:0]                   shadow_idx_s;

    memory_window_base #(
        .VALUE_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH  (MEMORY_ADDRESS_WIDTH),
        .WINDOW      (MEMORY_ELEMENTS)
    ) u_instr_base (
        .value_i (pc_in),
        .base_o  (ibase_d)
    );

    memory_window_base #(
        .VALUE_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH  (MEMORY_ADDRESS_WIDTH),
        .WINDOW      (MEMORY_ELEMENTS)
    ) u_data_base (
        .value_i (data_address_in),
        .base_o  (dbase_d)
    );

    assign shadow_idx_s = SW'(cyc_q - CW'(1));

    // Sequencer: cyc_q holds the cycle number whose outputs are registered at the next edge.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q       <= ST_IDLE;
            cyc_q         <= {CW{1'b0}};
            ibase_q       <= {MEMORY_ADDRESS_WIDTH{1'b0}};
            dbase_q       <= {MEMORY_ADDRESS_WIDTH{1'b0}};
            instr_raddr_q <= {MEMORY_ADDRESS_WIDTH{1'b0}};
            data_raddr_q  <= {MEMORY_ADDRESS_WIDTH{1'b0}};
            aux_waddr_q   <= {AUX_ADDRESS_WIDTH{1'b0}};
            aux_wdata_q   <= {DATA_WIDTH{1'b0}};
            aux_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < CPU_ELEMENTS; i++) begin
                shadow_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            aux_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (refresh_in) begin
                        shadow_q[AUX_PC]        <= pc_in;
                        shadow_q[AUX_INSTR_IN]  <= instr_in;
                        shadow_q[AUX_DATA_ADDR] <= data_address_in;
                        shadow_q[AUX_DATA_IN]   <= data_in;
                        shadow_q[AUX_IR]        <= ir_in;
                        shadow_q[AUX_ACC]       <= acc_in;
                        shadow_q[AUX_ALU_A]     <= alu_a_in;
                        shadow_q[AUX_ALU_B]     <= alu_b_in;
                        shadow_q[AUX_CLOCK]     <= {{(DATA_WIDTH-1){1'b0}}, clock_level_in};
                        shadow_q[AUX_STATUS]    <= {{(DATA_WIDTH-2){1'b0}}, status_z_in, status_n_in};
                        ibase_q                 <= ibase_d;
                        dbase_q                 <= dbase_d;
                        cyc_q                   <= CW'(1);
                        state_q                 <= ST_CPU;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CPU: begin
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    aux_we_q    <= 1'b1;
                    aux_waddr_q <= AUX_ADDRESS_WIDTH'(cyc_q - CW'(1));
                    aux_wdata_q <= shadow_q[shadow_idx_s];
                    cyc_q       <= cyc_q + CW'(1);
                    if (cyc_q == CPU_LAST) begin
                        state_q <= ST_MEM;
                    end else begin
                        state_q <= ST_CPU;
                    end
                end
                ST_MEM: begin
                    cyc_q <= cyc_q + CW'(1);
                    if ((cyc_q >= I_ISSUE_FIRST) && (cyc_q <= I_ISSUE_LAST)) begin
                        instr_raddr_q <= ibase_q + MEMORY_ADDRESS_WIDTH'(cyc_q - I_ISSUE_FIRST);
                    end
                    if ((cyc_q >= D_ISSUE_FIRST) && (cyc_q <= D_ISSUE_LAST)) begin
                        data_raddr_q <= dbase_q + MEMORY_ADDRESS_WIDTH'(cyc_q - D_ISSUE_FIRST);
                    end
                    if ((cyc_q >= I_WR_FIRST) && (cyc_q <= I_WR_LAST)) begin
                        aux_we_q    <= 1'b1;
                        aux_waddr_q <= AUX_ADDRESS_WIDTH'(AUX_INSTR_BASE) + AUX_ADDRESS_WIDTH'(cyc_q - I_WR_FIRST);
                        aux_wdata_q <= instr_rdata_in;
                    end else if ((cyc_q >= D_WR_FIRST) && (cyc_q <= D_WR_LAST)) begin
                        aux_we_q    <= 1'b1;
                        aux_waddr_q <= AUX_ADDRESS_WIDTH'(AUX_DATA_BASE) + AUX_ADDRESS_WIDTH'(cyc_q - D_WR_FIRST);
                        aux_wdata_q <= data_rdata_in;
                    end
                    if (cyc_q == DONE_CYC) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_MEM;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AUX_WRITER_OVERRUN_FLAG_EN
    logic overrun_q;

    // Sticky record of start requests that arrived while a sequence was still in flight.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            overrun_q <= 1'b0;
        end else if (refresh_in && (busy_q || done_q)) begin
            overrun_q <= 1'b1;
        end else begin
            overrun_q <= overrun_q;
        end
    end

    assign overrun_out = overrun_q;
`else
    // Refreshes arriving while busy are simply dropped with no indication.
`endif

    assign instr_raddress_out = instr_raddr_q;
    assign data_raddress_out  = data_raddr_q;
    assign aux_waddress_out   = aux_waddr_q;
    assign aux_wdata_out      = aux_wdata_q;
    assign aux_we_out         = aux_we_q;
    assign busy_out           = busy_q;
    assign done_out           = done_q;

endmodule

// File: tb/tb_aux_memory_writer.sv
// Directed self-checking bench for aux_memory_writer; checks overrun_out when AUX_WRITER_OVERRUN_FLAG_EN is defined.
module tb_aux_memory_writer;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        refresh_in;
    logic [15:0] pc_in, instr_in, data_address_in, data_in, ir_in, acc_in, alu_a_in, alu_b_in;
    logic        clock_level_in, status_z_in, status_n_in;
    logic [10:0] instr_raddress_out, data_raddress_out;
    logic [15:0] instr_rdata_in, data_rdata_in;
    logic [4:0]  aux_waddress_out;
    logic [15:0] aux_wdata_out;
    logic        aux_we_out, busy_out, done_out;
`ifdef AUX_WRITER_OVERRUN_FLAG_EN
    logic        overrun_out;
    logic        ovr_exp = 1'b0;
`endif

    logic [15:0] instr_mem [2048];
    logic [15:0] data_mem  [2048];
    logic [15:0] exp_cpu   [10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_cyc  = 0;

    aux_memory_writer dut (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .refresh_in         (refresh_in),
        .pc_in              (pc_in),
        .instr_in           (instr_in),
        .data_address_in    (data_address_in),
        .data_in            (data_in),
        .ir_in              (ir_in),
        .acc_in             (acc_in),
        .alu_a_in           (alu_a_in),
        .alu_b_in           (alu_b_in),
        .clock_level_in     (clock_level_in),
        .status_z_in        (status_z_in),
        .status_n_in        (status_n_in),
        .instr_raddress_out (instr_raddress_out),
        .instr_rdata_in     (instr_rdata_in),
        .data_raddress_out  (data_raddress_out),
        .data_rdata_in      (data_rdata_in),
        .aux_waddress_out   (aux_waddress_out),
        .aux_wdata_out      (aux_wdata_out),
        .aux_we_out         (aux_we_out),
        .busy_out           (busy_out),
`ifdef AUX_WRITER_OVERRUN_FLAG_EN
        .done_out           (done_out),
        .overrun_out        (overrun_out)
`else
        .done_out           (done_out)
`endif
    );

    always #5 clock_in = ~clock_in;

    // Synchronous-read instruction and data memories with one cycle of latency.
    always @(posedge clock_in) begin
        instr_rdata_in <= instr_mem[instr_raddress_out];
        data_rdata_in  <= data_mem[data_raddress_out];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cur_cyc, got, exp);
        end
    endtask

    task automatic set_cpu(input logic [15:0] pc, input logic [15:0] da, input logic [15:0] acc,
                           input logic clk_l, input logic z, input logic n);
        pc_in = pc;               exp_cpu[0] = pc;
        instr_in = pc ^ 16'h1234; exp_cpu[1] = pc ^ 16'h1234;
        data_address_in = da;     exp_cpu[2] = da;
        data_in = da + 16'h0101;  exp_cpu[3] = da + 16'h0101;
        ir_in = 16'h3C5A;         exp_cpu[4] = 16'h3C5A;
        acc_in = acc;             exp_cpu[5] = acc;
        alu_a_in = 16'h1111;      exp_cpu[6] = 16'h1111;
        alu_b_in = 16'h2222;      exp_cpu[7] = 16'h2222;
        clock_level_in = clk_l;   exp_cpu[8] = {15'd0, clk_l};
        status_z_in = z;
        status_n_in = n;          exp_cpu[9] = {14'd0, z, n};
    endtask

    // One refresh sequence; extra re-requests at cycles 5/33, abort_at>0 resets at that cycle.
    task automatic run_sequence(input int ibase, input int dbase, input bit extra, input int abort_at);
        refresh_in = 1'b1;
        @(posedge clock_in); #1;
        refresh_in = 1'b0;
        pc_in = ~pc_in; instr_in = ~instr_in; data_address_in = ~data_address_in; data_in = ~data_in;
        ir_in = ~ir_in; acc_in = ~acc_in; alu_a_in = ~alu_a_in; alu_b_in = ~alu_b_in;
        clock_level_in = ~clock_level_in; status_z_in = ~status_z_in; status_n_in = ~status_n_in;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clock_in); #1;
            cur_cyc = k;
            refresh_in = 1'b0;
            if (abort_at != 0 && k > abort_at) begin
                reset_in = 1'b0;
                check_eq("abort_we", 32'(aux_we_out), 32'd0);
                check_eq("abort_busy", 32'(busy_out), 32'd0);
                check_eq("abort_done", 32'(done_out), 32'd0);
`ifdef AUX_WRITER_OVERRUN_FLAG_EN
                check_eq("abort_overrun", 32'(overrun_out), 32'd0);
`endif
                if (k >= abort_at + 3) break;
            end else begin
                bit exp_we;
                exp_we = (k <= 10) || (k >= 13 && k <= 32);
                check_eq("we", 32'(aux_we_out), 32'(exp_we));
                if (k <= 10) begin
                    check_eq("waddr_cpu", 32'(aux_waddress_out), 32'(k - 1));
                    check_eq("wdata_cpu", 32'(aux_wdata_out), 32'(exp_cpu[k-1]));
                end else if (k >= 13 && k <= 22) begin
                    check_eq("waddr_instr", 32'(aux_waddress_out), 32'(k - 3));
                    check_eq("wdata_instr", 32'(aux_wdata_out), 32'(instr_mem[ibase + k - 13]));
                end else if (k >= 23 && k <= 32) begin
                    check_eq("waddr_data", 32'(aux_waddress_out), 32'(k - 3));
                    check_eq("wdata_data", 32'(aux_wdata_out), 32'(data_mem[dbase + k - 23]));
                end
                if (k >= 11 && k <= 20) check_eq("instr_raddr", 32'(instr_raddress_out), 32'(ibase + k - 11));
                if (k >= 21) check_eq("instr_raddr_hold", 32'(instr_raddress_out), 32'(ibase + 9));
                if (k >= 21 && k <= 30) check_eq("data_raddr", 32'(data_raddress_out), 32'(dbase + k - 21));
                if (k >= 31) check_eq("data_raddr_hold", 32'(data_raddress_out), 32'(dbase + 9));
                check_eq("busy", 32'(busy_out), 32'(k <= 32));
                check_eq("done", 32'(done_out), 32'(k == 33));
`ifdef AUX_WRITER_OVERRUN_FLAG_EN
                if (extra && k == 6) ovr_exp = 1'b1;
                check_eq("overrun", 32'(overrun_out), 32'(ovr_exp));
`endif
            end
            if (abort_at != 0 && k == abort_at) begin
                reset_in = 1'b1;
`ifdef AUX_WRITER_OVERRUN_FLAG_EN
                ovr_exp = 1'b0;
`endif
            end
            if (extra && (k == 5 || k == 33)) refresh_in = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            instr_mem[i] = 16'(i) ^ 16'hA5A5;
            data_mem[i]  = 16'(i * 7 + 5);
        end
        reset_in   = 1'b1;
        refresh_in = 1'b1;
        set_cpu(16'h0003, 16'h0100, 16'h4321, 1'b0, 1'b0, 1'b1);

        // Reset held three cycles with refresh asserted: everything at zero.
        repeat (3) @(posedge clock_in);
        #1;
        check_eq("rst_we", 32'(aux_we_out), 32'd0);
        check_eq("rst_waddr", 32'(aux_waddress_out), 32'd0);
        check_eq("rst_wdata", 32'(aux_wdata_out), 32'd0);
        check_eq("rst_busy", 32'(busy_out), 32'd0);
        check_eq("rst_done", 32'(done_out), 32'd0);
        check_eq("rst_iraddr", 32'(instr_raddress_out), 32'd0);
        check_eq("rst_draddr", 32'(data_raddress_out), 32'd0);
`ifdef AUX_WRITER_OVERRUN_FLAG_EN
        check_eq("rst_overrun", 32'(overrun_out), 32'd0);
`endif
        reset_in   = 1'b0;
        refresh_in = 1'b0;
        @(posedge clock_in); #1;
        check_eq("idle_busy", 32'(busy_out), 32'd0);
        check_eq("idle_we", 32'(aux_we_out), 32'd0);

        // Nominal window placement.
        set_cpu(16'h0003, 16'h0100, 16'h4321, 1'b0, 1'b0, 1'b1);
        run_sequence(32'h000, 32'h0FC, 1'b0, 0);
        // Boundary clamps on both windows.
        set_cpu(16'h07FE, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1);
        run_sequence(32'h7F6, 32'h000, 1'b0, 0);
        set_cpu(16'h0005, 16'h07FB, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_sequence(32'h001, 32'h7F6, 1'b0, 0);
        set_cpu(16'h07FA, 16'hFFFF, 16'h0003, 1'b1, 1'b0, 1'b1);
        run_sequence(32'h7F6, 32'h7F6, 1'b0, 0);
        set_cpu(16'h07FB, 16'h0004, 16'h0004, 1'b0, 1'b1, 1'b0);
        run_sequence(32'h7F6, 32'h000, 1'b0, 0);
        // Flag packing and snapshot coherence.
        set_cpu(16'h0200, 16'h0300, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        run_sequence(32'h1FC, 32'h2FC, 1'b0, 0);
        // Refreshes while busy and in the done cycle are dropped.
        set_cpu(16'h0400, 16'h0010, 16'h5A5A, 1'b0, 1'b0, 1'b1);
        run_sequence(32'h3FC, 32'h00C, 1'b1, 0);
        // Reset mid-sequence, then a full clean sequence.
        set_cpu(16'h0123, 16'h0456, 16'h7777, 1'b1, 1'b0, 1'b0);
        run_sequence(32'h11F, 32'h452, 1'b0, 25);
        set_cpu(16'h0050, 16'h0060, 16'hCAFE, 1'b0, 1'b1, 1'b1);
        run_sequence(32'h04C, 32'h05C, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
